// File: rtl/mac_pkg.sv
// Shared MAC-subsystem widths and the group-accumulator state encoding.
package mac_pkg;

  localparam int PP_W  = 15;
  localparam int EXP_W = 6;
  localparam int SUM_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/pp_group_accumulate_if.sv
// Term stream in from the aligner, group result out toward the normaliser.
interface pp_group_accumulate_if;
    import mac_pkg::*;

    logic [PP_W-1:0]  i_align_pp;
    logic [EXP_W-1:0] i_max_exp;
    logic             i_valid;
    logic             i_clear;
    logic [SUM_W-1:0] o_sum;
    logic [EXP_W-1:0] o_exp;
    logic             o_err;
    logic             o_valid;

    modport master (
        output i_align_pp, i_max_exp, i_valid, i_clear,
        input  o_sum, o_exp, o_err, o_valid
    );

    modport slave (
        input  i_align_pp, i_max_exp, i_valid, i_clear,
        output o_sum, o_exp, o_err, o_valid
    );

endinterface

// File: rtl/pp_narrow_sat.sv
// Narrows the full-width group sum to 16 bits: saturating when PP_ACC_SAT_EN
// is defined, otherwise plain truncation (wrap).
module pp_narrow_sat
    import mac_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [SUM_W-1:0] sum_o
);

`ifdef PP_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_s;
    assign acc_s = acc_i;

    // NOTE: default assignment first so every path drives sum_o (no latch).
    always_comb begin
        sum_o = acc_i[SUM_W-1:0];
        if (acc_s > SAT_MAX) begin
            sum_o = 16'h7FFF;
        end else if (acc_s < SAT_MIN) begin
            sum_o = 16'h8000;
        end
    end
`else
    assign sum_o = acc_i[SUM_W-1:0];

    if (ACC_W > SUM_W) begin : g_drop_hi
        logic unused_hi;
        assign unused_hi = ^acc_i[ACC_W-1:SUM_W];
    end
`endif

endmodule

// File: rtl/pp_group_accumulate.sv
// Sums groups of N_TERMS aligned partial products at full width and emits one
// tagged, narrowed group sum per group.
module pp_group_accumulate
    import mac_pkg::*;
#(
    parameter int N_TERMS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pp_group_accumulate_if.slave bus
);

    localparam int ACC_W = PP_W + $clog2(N_TERMS);
    localparam int CNT_W = $clog2(N_TERMS);

    state_e                  state_q;
    logic [CNT_W-1:0]        count_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] pp_ext;
    logic [EXP_W-1:0]        exp_q;
    logic                    err_q;
    logic                    err_d;
    logic                    last_term;
    logic [SUM_W-1:0]        narrow_sum;
    logic [SUM_W-1:0]        sum_out_q;
    logic [EXP_W-1:0]        exp_out_q;
    logic                    err_out_q;
    logic                    valid_out_q;

    assign pp_ext    = {{(ACC_W-PP_W){bus.i_align_pp[PP_W-1]}}, bus.i_align_pp};
    assign acc_d     = acc_q + pp_ext;
    assign err_d     = err_q | (bus.i_max_exp != exp_q);
    assign last_term = (state_q == ACC) && (count_q == CNT_W'(N_TERMS - 1));

    // The closing term must land in the output, so narrow the next-acc value.
    pp_narrow_sat #(.ACC_W(ACC_W)) u_narrow (
        .acc_i (acc_d),
        .sum_o (narrow_sum)
    );

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            acc_q       <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            sum_out_q   <= '0;
            exp_out_q   <= '0;
            err_out_q   <= 1'b0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= 1'b0;
            if (bus.i_clear) begin
                state_q <= IDLE;
                count_q <= '0;
                acc_q   <= '0;
            end else if (bus.i_valid) begin
                case (state_q)
                    IDLE: begin
                        acc_q   <= pp_ext;
                        exp_q   <= bus.i_max_exp;
                        err_q   <= 1'b0;
                        count_q <= CNT_W'(1);
                        state_q <= ACC;
                    end
                    ACC: begin
                        if (last_term) begin
                            sum_out_q   <= narrow_sum;
                            exp_out_q   <= exp_q;
                            err_out_q   <= err_d;
                            valid_out_q <= 1'b1;
                            count_q     <= '0;
                            acc_q       <= '0;
                            state_q     <= IDLE;
                        end else begin
                            acc_q   <= acc_d;
                            err_q   <= err_d;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_sum   = sum_out_q;
    assign bus.o_exp   = exp_out_q;
    assign bus.o_err   = err_out_q;
    assign bus.o_valid = valid_out_q;

endmodule

// File: tb/tb_pp_group_accumulate.sv
// Directed bench for pp_group_accumulate; overflow expectation follows PP_ACC_SAT_EN.
module tb_pp_group_accumulate;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   pulse_cnt = 0;
    int   consec_cnt = 0;
    int   pulse_base;
    logic prev_valid = 1'b0;

    pp_group_accumulate_if bus ();

    pp_group_accumulate #(.N_TERMS(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
        if (bus.o_valid === 1'b1 && prev_valid) consec_cnt <= consec_cnt + 1;
        prev_valid <= (bus.o_valid === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one cycle of input, then land 1 time unit after the rising edge.
    task automatic step(input logic [14:0] pp, input logic [5:0] ex, input logic v, input logic clr);
        bus.i_align_pp = pp;
        bus.i_max_exp  = ex;
        bus.i_valid    = v;
        bus.i_clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(15'h0, 6'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.i_align_pp = '0;
        bus.i_max_exp  = '0;
        bus.i_valid    = 1'b0;
        bus.i_clear    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(bus.o_sum), 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        rst = 1'b0;
        idle();

        // Basic group: 8 x 0x0800 at exp 20
        pulse_base = pulse_cnt;
        for (int i = 0; i < 7; i++) step(15'h0800, 6'd20, 1'b1, 1'b0);
        check("basic_early_valid", 32'(bus.o_valid), 32'h0);
        step(15'h0800, 6'd20, 1'b1, 1'b0);
        check("basic_valid", 32'(bus.o_valid), 32'h1);
        check("basic_sum", 32'(bus.o_sum), 32'h4000);
        check("basic_exp", 32'(bus.o_exp), 32'd20);
        check("basic_err", 32'(bus.o_err), 32'h0);
        idle();
        check("basic_pulse_low", 32'(bus.o_valid), 32'h0);
        check("basic_sum_hold", 32'(bus.o_sum), 32'h4000);
        check("basic_pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        // Asynchronous reset mid-group after 3 terms
        for (int i = 0; i < 3; i++) step(15'h0001, 6'd5, 1'b1, 1'b0);
        bus.i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_sum", 32'(bus.o_sum), 32'h0);
        check("arst_exp", 32'(bus.o_exp), 32'h0);
        check("arst_err", 32'(bus.o_err), 32'h0);
        check("arst_valid", 32'(bus.o_valid), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulse_base = pulse_cnt;
        for (int i = 0; i < 7; i++) step(15'h0001, 6'd5, 1'b1, 1'b0);
        check("post_rst_early_valid", 32'(bus.o_valid), 32'h0);
        step(15'h0001, 6'd5, 1'b1, 1'b0);
        check("post_rst_valid", 32'(bus.o_valid), 32'h1);
        check("post_rst_sum", 32'(bus.o_sum), 32'h8);
        idle();
        check("post_rst_pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        // Signs and bubbles: +1000 / -1000 alternating with random gaps
        pulse_base = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 3)) idle();
            step((i % 2 == 0) ? 15'd1000 : 15'h7C18, 6'd7, 1'b1, 1'b0);
        end
        check("sign_valid", 32'(bus.o_valid), 32'h1);
        check("sign_sum", 32'(bus.o_sum), 32'h0);
        check("sign_exp", 32'(bus.o_exp), 32'd7);
        idle();
        check("sign_pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        // Overflow: 8 x 0x3FFF = 131064
        for (int i = 0; i < 8; i++) step(15'h3FFF, 6'd1, 1'b1, 1'b0);
        check("ovf_valid", 32'(bus.o_valid), 32'h1);
`ifdef PP_ACC_SAT_EN
        check("ovf_sum", 32'(bus.o_sum), 32'h7FFF);
`else
        check("ovf_sum", 32'(bus.o_sum), 32'hFFF8);
`endif
        idle();

        // Clear with simultaneous valid, then a group with one exp mismatch
        pulse_base = pulse_cnt;
        for (int i = 0; i < 3; i++) step(15'h0007, 6'd20, 1'b1, 1'b0);
        step(15'h0007, 6'd20, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(15'h0002, (i == 4) ? 6'd21 : 6'd20, 1'b1, 1'b0);
        check("clr_early_valid", 32'(bus.o_valid), 32'h0);
        step(15'h0002, 6'd20, 1'b1, 1'b0);
        check("clr_valid", 32'(bus.o_valid), 32'h1);
        check("clr_sum", 32'(bus.o_sum), 32'd16);
        check("clr_exp", 32'(bus.o_exp), 32'd20);
        check("clr_err", 32'(bus.o_err), 32'h1);
        idle();
        check("clr_pulses", 32'(pulse_cnt - pulse_base), 32'd1);

        // Back-to-back: 16 consecutive terms of 1
        pulse_base = pulse_cnt;
        for (int i = 1; i <= 16; i++) begin
            step(15'h0001, 6'd3, 1'b1, 1'b0);
            if (i == 8) begin
                check("b2b_valid_9", 32'(bus.o_valid), 32'h1);
                check("b2b_sum_9", 32'(bus.o_sum), 32'h8);
                check("b2b_err_9", 32'(bus.o_err), 32'h0);
            end
            if (i == 9) check("b2b_gap_10", 32'(bus.o_valid), 32'h0);
            if (i == 16) begin
                check("b2b_valid_17", 32'(bus.o_valid), 32'h1);
                check("b2b_sum_17", 32'(bus.o_sum), 32'h8);
                check("b2b_exp_17", 32'(bus.o_exp), 32'd3);
            end
        end
        idle();
        idle();
        check("b2b_pulses", 32'(pulse_cnt - pulse_base), 32'd2);
        check("no_consecutive_valid", 32'(consec_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
